// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared encodings for the pipeline hazard controller
// Purpose: forwarding-mux select codes (MX1/MX2) and the hazard FSM state type.
// Ports: none (package).
package mips_pipe_pkg;

    // Forwarding mux selects for ID-stage operands
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
    localparam logic [1:0] FWD_EX  = 2'b01;  // ALU result of the instruction in EX
    localparam logic [1:0] FWD_MEM = 2'b10;  // MEM stage result (ALU or load data)
    localparam logic [1:0] FWD_WB  = 2'b11;  // write-back value PW

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FREEZE     = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - per-operand match and forwarding priority encoder
// Purpose: compares one ID source specifier against EX, MEM and WB destinations
//          and picks the youngest producer; flags a load in EX feeding it.
// Ports:
//   src, uses                       source specifier and its read flag
//   ex_reg, ex_rf_enable, ex_load   destination, write enable, load flag in EX
//   mem_reg, mem_rf_enable          destination and write enable in MEM
//   wb_reg, wb_rf_enable            destination and write enable in WB
//   sel                             2-bit MX select (mips_pipe_pkg FWD_*)
//   ex_load_match                   operand depends on a load still in EX
module hazard_fwd_sel
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             uses,
    input  logic [REG_W-1:0] ex_reg,
    input  logic             ex_rf_enable,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_reg,
    input  logic             mem_rf_enable,
    input  logic [REG_W-1:0] wb_reg,
    input  logic             wb_rf_enable,
    output logic [1:0]       sel,
    output logic             ex_load_match
);

    logic src_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // $0 is hardwired to zero, so it never needs a producer
    assign src_live = uses && (src != '0);

    assign ex_hit  = src_live && ex_rf_enable  && (ex_reg  == src);
    assign mem_hit = src_live && mem_rf_enable && (mem_reg == src);
    assign wb_hit  = src_live && wb_rf_enable  && (wb_reg  == src);

    assign ex_load_match = ex_hit && ex_load;

    // Youngest producer wins: EX holds the newest value for the register
    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard detection and forwarding control for the 5-stage pipeline
// Purpose: drives PC/IF-ID load enables, ID/EX bubble, pipeline freeze and
//          MX1/MX2 forwarding selects from stage destination/control state.
// Optional feature: PIPE_STALL_STATS_EN adds the saturating STALL_COUNT port.
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   ID_RS, ID_RT, ID_USES_RS/RT      IF/ID source operands and read flags
//   EX_REG, EX_RF_ENABLE, EX_LOAD_INSTR   instruction in EX
//   MEM_REG, MEM_RF_ENABLE           instruction in MEM
//   WB_REG, WB_RF_ENABLE             instruction in WB
//   MEM_BUSY                         data memory not ready
//   PC_LE, IF_ID_LE                  front-end load enables
//   ID_EX_NOP                        zero ID/EX control (bubble)
//   PIPE_HOLD                        ID/EX, EX/MEM, MEM/WB hold
//   FWD_A, FWD_B                     MX1/MX2 selects
//   STALL_COUNT                      stall cycle counter (stats build only)
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_RS,
    input  logic [REG_W-1:0] ID_RT,
    input  logic             ID_USES_RS,
    input  logic             ID_USES_RT,
    input  logic [REG_W-1:0] EX_REG,
    input  logic             EX_RF_ENABLE,
    input  logic             EX_LOAD_INSTR,
    input  logic [REG_W-1:0] MEM_REG,
    input  logic             MEM_RF_ENABLE,
    input  logic [REG_W-1:0] WB_REG,
    input  logic             WB_RF_ENABLE,
    input  logic             MEM_BUSY,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_NOP,
    output logic             PIPE_HOLD,
    output logic [1:0]       FWD_A,
    output logic [1:0]       FWD_B
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] STALL_COUNT
`endif
);

    hazard_state_t state;
    hazard_state_t state_next;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       load_match_a;
    logic       load_match_b;
    logic       load_use;

    hazard_fwd_sel #(.REG_W(REG_W)) u_sel_a (
        .src           (ID_RS),
        .uses          (ID_USES_RS),
        .ex_reg        (EX_REG),
        .ex_rf_enable  (EX_RF_ENABLE),
        .ex_load       (EX_LOAD_INSTR),
        .mem_reg       (MEM_REG),
        .mem_rf_enable (MEM_RF_ENABLE),
        .wb_reg        (WB_REG),
        .wb_rf_enable  (WB_RF_ENABLE),
        .sel           (sel_a),
        .ex_load_match (load_match_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_sel_b (
        .src           (ID_RT),
        .uses          (ID_USES_RT),
        .ex_reg        (EX_REG),
        .ex_rf_enable  (EX_RF_ENABLE),
        .ex_load       (EX_LOAD_INSTR),
        .mem_reg       (MEM_REG),
        .mem_rf_enable (MEM_RF_ENABLE),
        .wb_reg        (WB_REG),
        .wb_rf_enable  (WB_RF_ENABLE),
        .sel           (sel_b),
        .ex_load_match (load_match_b)
    );

    assign load_use = load_match_a || load_match_b;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        PC_LE      = 1'b1;
        IF_ID_LE   = 1'b1;
        ID_EX_NOP  = 1'b0;
        PIPE_HOLD  = 1'b0;
        FWD_A      = sel_a;
        FWD_B      = sel_b;
        state_next = ST_RUN;

        if (Reset) begin
            PC_LE     = 1'b0;
            IF_ID_LE  = 1'b0;
            ID_EX_NOP = 1'b1;
            FWD_A     = FWD_RF;
            FWD_B     = FWD_RF;
        end else if (MEM_BUSY) begin
            // Freeze beats load-use; detection is redone once memory is ready
            PC_LE      = 1'b0;
            IF_ID_LE   = 1'b0;
            PIPE_HOLD  = 1'b1;
            state_next = ST_FREEZE;
        end else begin
            case (state)
                ST_LOAD_STALL: begin
                    // Load has moved to MEM; the bubble is in EX, so release
                    state_next = ST_RUN;
                end
                default: begin
                    if (load_use) begin
                        PC_LE      = 1'b0;
                        IF_ID_LE   = 1'b0;
                        ID_EX_NOP  = 1'b1;
                        state_next = ST_LOAD_STALL;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic [CNT_W-1:0] stall_count;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (!PC_LE && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign STALL_COUNT = stall_count;
`else
    // Keeps CNT_W referenced when the counter is compiled out
    logic [CNT_W-1:0] stall_cnt_unused;
    assign stall_cnt_unused = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 32;

    logic             Clk;
    logic             Reset;
    logic [REG_W-1:0] ID_RS, ID_RT;
    logic             ID_USES_RS, ID_USES_RT;
    logic [REG_W-1:0] EX_REG, MEM_REG, WB_REG;
    logic             EX_RF_ENABLE, EX_LOAD_INSTR, MEM_RF_ENABLE, WB_RF_ENABLE;
    logic             MEM_BUSY;
    logic             PC_LE, IF_ID_LE, ID_EX_NOP, PIPE_HOLD;
    logic [1:0]       FWD_A, FWD_B;
`ifdef PIPE_STALL_STATS_EN
    logic [CNT_W-1:0] STALL_COUNT;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ID_RS         (ID_RS),
        .ID_RT         (ID_RT),
        .ID_USES_RS    (ID_USES_RS),
        .ID_USES_RT    (ID_USES_RT),
        .EX_REG        (EX_REG),
        .EX_RF_ENABLE  (EX_RF_ENABLE),
        .EX_LOAD_INSTR (EX_LOAD_INSTR),
        .MEM_REG       (MEM_REG),
        .MEM_RF_ENABLE (MEM_RF_ENABLE),
        .WB_REG        (WB_REG),
        .WB_RF_ENABLE  (WB_RF_ENABLE),
        .MEM_BUSY      (MEM_BUSY),
        .PC_LE         (PC_LE),
        .IF_ID_LE      (IF_ID_LE),
        .ID_EX_NOP     (ID_EX_NOP),
        .PIPE_HOLD     (PIPE_HOLD),
        .FWD_A         (FWD_A),
        .FWD_B         (FWD_B)
`ifdef PIPE_STALL_STATS_EN
        ,
        .STALL_COUNT   (STALL_COUNT)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // bubble_issued: a load-use bubble was inserted last cycle and not undone
    bit          bubble_issued = 0;
    longint      model_count   = 0;

    function automatic logic [1:0] m_fwd(input logic [REG_W-1:0] src, input logic uses);
        logic [REG_W-1:0] dst [3];
        logic             wen [3];
        dst[0] = EX_REG;  wen[0] = EX_RF_ENABLE;
        dst[1] = MEM_REG; wen[1] = MEM_RF_ENABLE;
        dst[2] = WB_REG;  wen[2] = WB_RF_ENABLE;
        if (!uses || src == 0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (wen[k] && dst[k] == src) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit m_load_use();
        bit a, b;
        a = ID_USES_RS && ID_RS != 0 && EX_RF_ENABLE && EX_LOAD_INSTR && EX_REG == ID_RS;
        b = ID_USES_RT && ID_RT != 0 && EX_RF_ENABLE && EX_LOAD_INSTR && EX_REG == ID_RT;
        return a || b;
    endfunction

    // returns {pc_le, if_id_le, nop, hold, fwd_a, fwd_b}
    function automatic logic [7:0] m_out();
        if (Reset) return 8'b0010_0000;
        if (MEM_BUSY) return {4'b0001, m_fwd(ID_RS, ID_USES_RS), m_fwd(ID_RT, ID_USES_RT)};
        if (!bubble_issued && m_load_use())
            return {4'b0010, m_fwd(ID_RS, ID_USES_RS), m_fwd(ID_RT, ID_USES_RT)};
        return {4'b1100, m_fwd(ID_RS, ID_USES_RS), m_fwd(ID_RT, ID_USES_RT)};
    endfunction

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge Clk);
            e = m_out();
            chk("model_pc_le",    32'(PC_LE),     32'(e[7]));
            chk("model_if_id_le", 32'(IF_ID_LE),  32'(e[6]));
            chk("model_nop",      32'(ID_EX_NOP), 32'(e[5]));
            chk("model_hold",     32'(PIPE_HOLD), 32'(e[4]));
            chk("model_fwd_a",    32'(FWD_A),     32'(e[3:2]));
            chk("model_fwd_b",    32'(FWD_B),     32'(e[1:0]));
`ifdef PIPE_STALL_STATS_EN
            chk("model_stall_count", STALL_COUNT, 32'(model_count));
`endif
            @(posedge Clk);
            e = m_out();
            if (Reset) begin
                bubble_issued = 0;
                model_count   = 0;
            end else begin
                bubble_issued = e[5];
                if (!e[7] && model_count < 64'hFFFF_FFFF) model_count++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        ID_RS = 0; ID_RT = 0; ID_USES_RS = 0; ID_USES_RT = 0;
        EX_REG = 0; EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0;
        MEM_REG = 0; MEM_RF_ENABLE = 0; WB_REG = 0; WB_RF_ENABLE = 0;
        MEM_BUSY = 0;
    endtask

    task automatic set_load_use();
        EX_REG = 5; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1;
        ID_RS = 5; ID_USES_RS = 1;
    endtask

    task automatic set_load_in_mem();
        EX_REG = 0; EX_RF_ENABLE = 0; EX_LOAD_INSTR = 0;
        MEM_REG = 5; MEM_RF_ENABLE = 1;
        ID_RS = 5; ID_USES_RS = 1;
    endtask

    initial begin
        Reset = 1'b1;
        clr();
        step();
        step();
        #2;
        chk("rst_pc_le", 32'(PC_LE), 0);
        chk("rst_if_id_le", 32'(IF_ID_LE), 0);
        chk("rst_nop", 32'(ID_EX_NOP), 1);
        chk("rst_hold", 32'(PIPE_HOLD), 0);
        chk("rst_fwd_a", 32'(FWD_A), 0);
        chk("rst_fwd_b", 32'(FWD_B), 0);

        step(); Reset = 1'b0; #2;
        chk("idle_pc_le", 32'(PC_LE), 1);
        chk("idle_nop", 32'(ID_EX_NOP), 0);

        // load-use then release with MEM forwarding
        step(); set_load_use(); #2;
        chk("lu_pc_le", 32'(PC_LE), 0);
        chk("lu_if_id_le", 32'(IF_ID_LE), 0);
        chk("lu_nop", 32'(ID_EX_NOP), 1);
        step(); set_load_in_mem(); #2;
        chk("lu_rel_pc_le", 32'(PC_LE), 1);
        chk("lu_rel_nop", 32'(ID_EX_NOP), 0);
        chk("lu_rel_fwd_a", 32'(FWD_A), 2);

        // forwarding priority on operand B
        step(); clr();
        EX_REG = 7; MEM_REG = 7; WB_REG = 7;
        EX_RF_ENABLE = 1; MEM_RF_ENABLE = 1; WB_RF_ENABLE = 1;
        ID_RT = 7; ID_USES_RT = 1; #2;
        chk("prio_ex", 32'(FWD_B), 1);
        step(); EX_RF_ENABLE = 0; #2;
        chk("prio_mem", 32'(FWD_B), 2);
        step(); MEM_RF_ENABLE = 0; #2;
        chk("prio_wb", 32'(FWD_B), 3);
        step(); ID_USES_RT = 0; #2;
        chk("prio_unused", 32'(FWD_B), 0);

        // register 0 never stalls or forwards
        step(); clr();
        ID_RS = 0; ID_USES_RS = 1; EX_REG = 0; EX_RF_ENABLE = 1; EX_LOAD_INSTR = 1; #2;
        chk("r0_pc_le", 32'(PC_LE), 1);
        chk("r0_fwd_a", 32'(FWD_A), 0);

        // reset arriving in LOAD_STALL
        step(); clr(); set_load_use(); #2;
        chk("rs_lu_nop", 32'(ID_EX_NOP), 1);
        step(); set_load_in_mem(); Reset = 1'b1; #2;
        chk("rs_mid_pc_le", 32'(PC_LE), 0);
        chk("rs_mid_nop", 32'(ID_EX_NOP), 1);
        chk("rs_mid_fwd_a", 32'(FWD_A), 0);
        step(); clr(); Reset = 1'b0; #2;
        chk("rs_after_pc_le", 32'(PC_LE), 1);
        chk("rs_after_fwd_a", 32'(FWD_A), 0);

        // 3-cycle freeze over a pending load-use
        step(); set_load_use(); MEM_BUSY = 1; #2;
        for (int i = 0; i < 3; i++) begin
            chk("frz_hold", 32'(PIPE_HOLD), 1);
            chk("frz_nop", 32'(ID_EX_NOP), 0);
            chk("frz_pc_le", 32'(PC_LE), 0);
            step();
            if (i == 2) MEM_BUSY = 0;
            #2;
        end
        chk("frz_lu_nop", 32'(ID_EX_NOP), 1);
        chk("frz_lu_hold", 32'(PIPE_HOLD), 0);
        step(); set_load_in_mem(); #2;
        chk("frz_rel_pc_le", 32'(PC_LE), 1);
        chk("frz_rel_fwd_a", 32'(FWD_A), 2);
`ifdef PIPE_STALL_STATS_EN
        chk("stats_count", STALL_COUNT, 4);
`endif

        // freeze arriving in LOAD_STALL discards the stall state
        step(); clr(); set_load_use(); #2;
        chk("fls_nop", 32'(ID_EX_NOP), 1);
        step(); set_load_in_mem(); MEM_BUSY = 1; #2;
        chk("fls_hold", 32'(PIPE_HOLD), 1);
        step(); MEM_BUSY = 0; #2;
        chk("fls_pc_le", 32'(PC_LE), 1);
        chk("fls_fwd_a", 32'(FWD_A), 2);

        step(); clr();
        step();
        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
